// File: rtl/rename_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rename_pkg
// Description : Shared defaults, tag/register-index types and the x0 index
//               for the rename register file.
// Revision    : 1.0
// ============================================================================
package rename_pkg;

    localparam int c_DEF_NUM_REGS = 32;
    localparam int c_DEF_XLEN     = 32;
    localparam int c_DEF_TAG_W    = 4;
    localparam int c_DEF_NUM_RD   = 3;
    localparam int c_DEF_REG_AW   = $clog2(c_DEF_NUM_REGS);

    typedef logic [c_DEF_TAG_W-1:0]  tag_t;
    typedef logic [c_DEF_REG_AW-1:0] reg_idx_t;

    localparam reg_idx_t c_X0 = '0;

endpackage
`default_nettype wire

// File: rtl/rename_lookup_port.sv
`default_nettype none
// ============================================================================
// Module      : rename_lookup_port
// Description : One source-operand lookup: selects busy/tag or value for the
//               addressed register. Same-cycle commit forwarding is enabled by
//               defining RENAME_COMMIT_BYPASS_EN.
// Revision    : 1.0
// ============================================================================
module rename_lookup_port
    import rename_pkg::*;
#(
    parameter int REG_AW = c_DEF_REG_AW,
    parameter int XLEN   = c_DEF_XLEN,
    parameter int TAG_W  = c_DEF_TAG_W
) (
    input  logic              i_en,
    input  logic [REG_AW-1:0] i_addr,
    input  logic              i_ent_busy,
    input  logic [TAG_W-1:0]  i_ent_tag,
    input  logic [XLEN-1:0]   i_ent_value,
    input  logic              i_cmt_valid,
    input  logic [REG_AW-1:0] i_cmt_rd,
    input  logic [TAG_W-1:0]  i_cmt_tag,
    input  logic [XLEN-1:0]   i_cmt_value,
    output logic              o_busy,
    output logic [TAG_W-1:0]  o_tag,
    output logic [XLEN-1:0]   o_value
);

    logic w_is_x0;
    logic w_bypass;

    assign w_is_x0 = (i_addr == REG_AW'(c_X0));

`ifdef RENAME_COMMIT_BYPASS_EN
    // The committing producer is exactly the one this register waits on.
    assign w_bypass = i_cmt_valid && i_ent_busy &&
                      (i_cmt_rd == i_addr) && (i_cmt_tag == i_ent_tag);
`else
    logic w_unused_cmt;
    assign w_unused_cmt = ^{i_cmt_valid, i_cmt_rd, i_cmt_tag, i_cmt_value};
    assign w_bypass     = 1'b0;
`endif

    always_comb begin
        o_busy  = 1'b0;
        o_tag   = '0;
        o_value = '0;
        if (i_en && !w_is_x0) begin
            if (w_bypass) begin
                o_value = i_cmt_value;
            end else if (i_ent_busy) begin
                o_busy = 1'b1;
                o_tag  = i_ent_tag;
            end else begin
                o_value = i_ent_value;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile
// Description : Architectural register file with per-register busy/tag rename
//               state, NUM_RD lookup ports, commit write-back and flush.
//               Optional macro: RENAME_COMMIT_BYPASS_EN (same-cycle forward).
// Revision    : 1.0
// ============================================================================
module rename_regfile
    import rename_pkg::*;
#(
    parameter  int NUM_REGS = c_DEF_NUM_REGS,
    parameter  int XLEN     = c_DEF_XLEN,
    parameter  int TAG_W    = c_DEF_TAG_W,
    parameter  int NUM_RD   = c_DEF_NUM_RD,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     cmt_valid,
    input  logic [REG_AW-1:0]        cmt_rd,
    input  logic [TAG_W-1:0]         cmt_tag,
    input  logic [XLEN-1:0]          cmt_value,
    input  logic                     rn_req,
    input  logic [TAG_W-1:0]         rn_id,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic                     rn_dst_en,
    input  logic [REG_AW-1:0]        rn_dst,
    input  logic [TAG_W-1:0]         rn_tag,
    input  logic                     flush,
    output logic                     rsp_valid,
    output logic [TAG_W-1:0]         rsp_id,
    output logic [NUM_RD-1:0]        rsp_busy,
    output logic [NUM_RD*TAG_W-1:0]  rsp_tag,
    output logic [NUM_RD*XLEN-1:0]   rsp_value
);

    logic [XLEN-1:0]  r_value [NUM_REGS];
    logic             r_busy  [NUM_REGS];
    logic [TAG_W-1:0] r_tag   [NUM_REGS];

    logic                    r_rsp_valid;
    logic [TAG_W-1:0]        r_rsp_id;
    logic [NUM_RD-1:0]       r_rsp_busy;
    logic [NUM_RD*TAG_W-1:0] r_rsp_tag;
    logic [NUM_RD*XLEN-1:0]  r_rsp_value;

    logic                    w_accept;
    logic [NUM_RD-1:0]       w_busy;
    logic [NUM_RD*TAG_W-1:0] w_tag;
    logic [NUM_RD*XLEN-1:0]  w_value;

    // A flush squashes the request arriving alongside it.
    assign w_accept = rn_req && !flush;

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
        logic [REG_AW-1:0] w_addr;
        assign w_addr = rd_addr[gi*REG_AW +: REG_AW];

        rename_lookup_port #(
            .REG_AW (REG_AW),
            .XLEN   (XLEN),
            .TAG_W  (TAG_W)
        ) u_port (
            .i_en        (rd_en[gi]),
            .i_addr      (w_addr),
            .i_ent_busy  (r_busy[w_addr]),
            .i_ent_tag   (r_tag[w_addr]),
            .i_ent_value (r_value[w_addr]),
            .i_cmt_valid (cmt_valid),
            .i_cmt_rd    (cmt_rd),
            .i_cmt_tag   (cmt_tag),
            .i_cmt_value (cmt_value),
            .o_busy      (w_busy[gi]),
            .o_tag       (w_tag[gi*TAG_W +: TAG_W]),
            .o_value     (w_value[gi*XLEN +: XLEN])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_value[r] <= '0;
                r_busy[r]  <= 1'b0;
                r_tag[r]   <= '0;
            end
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_busy  <= '0;
            r_rsp_tag   <= '0;
            r_rsp_value <= '0;
        end else if (rdy) begin
            r_rsp_valid <= w_accept;
            if (w_accept) begin
                r_rsp_id    <= rn_id;
                r_rsp_busy  <= w_busy;
                r_rsp_tag   <= w_tag;
                r_rsp_value <= w_value;
            end else begin
                r_rsp_id    <= '0;
                r_rsp_busy  <= '0;
                r_rsp_tag   <= '0;
                r_rsp_value <= '0;
            end
            // Entry 0 is never written after reset, so it stays idle and zero.
            for (int r = 1; r < NUM_REGS; r++) begin
                if (cmt_valid && (cmt_rd == REG_AW'(r))) begin
                    r_value[r] <= cmt_value;
                end
                if (flush) begin
                    r_busy[r] <= 1'b0;
                end else if (w_accept && rn_dst_en && (rn_dst == REG_AW'(r))) begin
                    r_busy[r] <= 1'b1;
                    r_tag[r]  <= rn_tag;
                end else if (cmt_valid && (cmt_rd == REG_AW'(r)) && (r_tag[r] == cmt_tag)) begin
                    r_busy[r] <= 1'b0;
                end
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_busy  = r_rsp_busy;
    assign rsp_tag   = r_rsp_tag;
    assign rsp_value = r_rsp_value;

endmodule
`default_nettype wire

// File: tb/tb_rename_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_rename_regfile
// Description : Directed and random checks of rename_regfile against an
//               array-based reference model.
// Revision    : 1.0
// ============================================================================
module tb_rename_regfile;
    import rename_pkg::*;

    localparam int NR = 32;
    localparam int XL = 32;
    localparam int TW = 4;
    localparam int NP = 3;
    localparam int AW = 5;
`ifdef RENAME_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, rdy, cmt_valid, rn_req, rn_dst_en, flush;
    reg_idx_t         cmt_rd, rn_dst;
    tag_t             cmt_tag, rn_id, rn_tag;
    logic [XL-1:0]    cmt_value;
    logic [NP-1:0]    rd_en;
    logic [NP*AW-1:0] rd_addr;
    logic             rsp_valid;
    tag_t             rsp_id;
    logic [NP-1:0]    rsp_busy;
    logic [NP*TW-1:0] rsp_tag;
    logic [NP*XL-1:0] rsp_value;

    rename_regfile dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_value(cmt_value),
        .rn_req(rn_req), .rn_id(rn_id), .rd_en(rd_en), .rd_addr(rd_addr),
        .rn_dst_en(rn_dst_en), .rn_dst(rn_dst), .rn_tag(rn_tag), .flush(flush),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_busy(rsp_busy),
        .rsp_tag(rsp_tag), .rsp_value(rsp_value)
    );

    logic [XL-1:0] m_value [NR];
    logic          m_busy  [NR];
    tag_t          m_tag   [NR];

    logic          exp_valid, exp_full;
    tag_t          exp_id;
    logic          exp_busy  [NP];
    tag_t          exp_tag   [NP];
    logic [XL-1:0] exp_value [NP];

    int errors = 0;
    int checks = 0;
    logic [NP*(XL+TW+1)+TW:0] snap;

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: lookups see the pre-edge state, then commit, rename, flush apply in priority order.
    task automatic model_step();
        bit acc;
        int a;
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_value[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
            exp_valid = 1'b0; exp_id = '0; exp_full = 1'b1;
            for (int i = 0; i < NP; i++) begin
                exp_busy[i] = 1'b0; exp_tag[i] = '0; exp_value[i] = '0;
            end
            return;
        end
        if (!rdy) return;
        exp_full  = 1'b0;
        acc       = rn_req && !flush;
        exp_valid = acc;
        exp_id    = acc ? rn_id : '0;
        for (int i = 0; i < NP; i++) begin
            a = int'(rd_addr[i*AW +: AW]);
            exp_busy[i] = 1'b0; exp_tag[i] = '0; exp_value[i] = '0;
            if (acc && rd_en[i] && a != 0) begin
                if (m_busy[a] && BYP && cmt_valid && int'(cmt_rd) == a && cmt_tag == m_tag[a])
                    exp_value[i] = cmt_value;
                else if (m_busy[a]) begin
                    exp_busy[i] = 1'b1; exp_tag[i] = m_tag[a];
                end else
                    exp_value[i] = m_value[a];
            end
        end
        if (cmt_valid && cmt_rd != 0) begin
            m_value[cmt_rd] = cmt_value;
            if (m_tag[cmt_rd] == cmt_tag) m_busy[cmt_rd] = 1'b0;
        end
        if (acc && rn_dst_en && rn_dst != 0) begin
            m_busy[rn_dst] = 1'b1; m_tag[rn_dst] = rn_tag;
        end
        if (flush)
            for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
    endtask

    task automatic check_outputs(input string tg);
        chk({tg, ".valid"}, rsp_valid, exp_valid);
        if (exp_full) begin
            chk({tg, ".id0"}, rsp_id, 0);
            chk({tg, ".busy0"}, rsp_busy, 0);
            chk({tg, ".tag0"}, rsp_tag, 0);
            chk({tg, ".value0"}, rsp_value, 0);
        end else if (exp_valid) begin
            chk({tg, ".id"}, rsp_id, exp_id);
            for (int i = 0; i < NP; i++) begin
                chk($sformatf("%s.busy%0d", tg, i), rsp_busy[i], exp_busy[i]);
                if (exp_busy[i])
                    chk($sformatf("%s.tag%0d", tg, i), rsp_tag[i*TW +: TW], exp_tag[i]);
                else
                    chk($sformatf("%s.value%0d", tg, i), rsp_value[i*XL +: XL], exp_value[i]);
            end
        end
    endtask

    task automatic tick(input string tg);
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tg);
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        cmt_valid = 1'b0; cmt_rd = '0; cmt_tag = '0; cmt_value = '0;
        rn_req = 1'b0; rn_id = '0; rd_en = '0; rd_addr = '0;
        rn_dst_en = 1'b0; rn_dst = '0; rn_tag = '0;
    endtask

    task automatic lookup(input int p, input int addr);
        rn_req = 1'b1;
        rn_id  = TW'(p + addr);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    task automatic rename(input int dst, input int tg);
        rn_req = 1'b1; rn_dst_en = 1'b1; rn_dst = AW'(dst); rn_tag = TW'(tg);
    endtask

    task automatic commit(input int rd, input int tg, input int val);
        cmt_valid = 1'b1; cmt_rd = AW'(rd); cmt_tag = TW'(tg); cmt_value = XL'(val);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick("reset");
        rdy = 1'b0;
        tick("reset_rdy0");

        // Rename then look up.
        idle(); rename(5, 3); tick("r5");
        idle(); lookup(0, 5); tick("lk5");
        chk("dir_busy_after_rename", rsp_busy[0], 1);
        chk("dir_tag_after_rename", rsp_tag[TW-1:0], 3);

        // Stale-tag commit keeps busy; matching commit releases.
        idle(); commit(5, 2, 'hAA); tick("cmt_stale");
        idle(); lookup(0, 5); tick("lk5b");
        chk("dir_stale_busy", rsp_busy[0], 1);
        chk("dir_stale_tag", rsp_tag[TW-1:0], 3);
        idle(); commit(5, 3, 'hBB); tick("cmt_match");
        idle(); lookup(0, 5); tick("lk5c");
        chk("dir_released_busy", rsp_busy[0], 0);
        chk("dir_released_value", rsp_value[XL-1:0], 'hBB);

        // Commit and lookup of the same busy register in one cycle.
        idle(); rename(5, 3); tick("r5b");
        idle(); lookup(0, 5); commit(5, 3, 'h1234); tick("bypass");
        chk("dir_bypass_busy", rsp_busy[0], BYP ? 0 : 1);
        chk("dir_bypass_data", BYP ? rsp_value[XL-1:0] : 128'(rsp_tag[TW-1:0]), BYP ? 'h1234 : 3);

        // Lookup sees pre-edge mapping when renamed in the same cycle.
        idle(); commit(1, 0, 9); tick("x1_init");
        idle(); lookup(0, 1); rename(1, 7); tick("lk_rn_x1");
        chk("dir_prerename_busy", rsp_busy[0], 0);
        chk("dir_prerename_value", rsp_value[XL-1:0], 9);
        idle(); lookup(0, 1); tick("lk_x1");
        chk("dir_postrename_busy", rsp_busy[0], 1);
        chk("dir_postrename_tag", rsp_tag[TW-1:0], 7);

        // Flush drops the request and clears busy state.
        idle(); rename(2, 1); tick("r2");
        idle(); rename(3, 2); tick("r3");
        idle(); flush = 1'b1; lookup(0, 2); rename(4, 6); tick("flush");
        chk("dir_flush_valid", rsp_valid, 0);
        idle(); lookup(0, 2); lookup(1, 3); lookup(2, 4); tick("post_flush");
        chk("dir_flush_x2", rsp_busy[0], 0);
        chk("dir_flush_x3", rsp_busy[1], 0);
        chk("dir_flush_x4", rsp_busy[2], 0);

        // Register 0 is hard-wired idle and zero.
        idle(); rename(0, 5); commit(0, 5, 'h55); tick("r0");
        idle(); lookup(0, 0); lookup(1, 5); tick("lk0");
        chk("dir_x0_busy", rsp_busy[0], 0);
        chk("dir_x0_value", rsp_value[XL-1:0], 0);

        // rdy low freezes outputs and state.
        snap = {rsp_valid, rsp_id, rsp_busy, rsp_tag, rsp_value};
        for (int k = 0; k < 3; k++) begin
            idle(); rdy = 1'b0; flush = k[0]; rename(5, 9); lookup(0, 1); commit(1, 7, 'h77);
            tick("hold");
            chk($sformatf("dir_hold%0d", k), {rsp_valid, rsp_id, rsp_busy, rsp_tag, rsp_value}, snap);
        end
        idle(); lookup(0, 1); lookup(1, 5); tick("after_hold");

        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rdy       = ($urandom_range(0, 7) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            rn_req    = ($urandom_range(0, 3) != 0);
            rn_id     = TW'($urandom);
            rn_dst_en = ($urandom_range(0, 1) == 1);
            rn_dst    = AW'($urandom_range(0, 7));
            rn_tag    = TW'($urandom);
            rd_en     = NP'($urandom);
            for (int p = 0; p < NP; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
            cmt_valid = ($urandom_range(0, 1) == 1);
            cmt_rd    = AW'($urandom_range(0, 7));
            cmt_tag   = ($urandom_range(0, 2) != 0) ? m_tag[cmt_rd] : TW'($urandom);
            cmt_value = $urandom;
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
